// File: rtl/vector_pkg.sv
// Shared vector-unit definitions: opcodes, the memory-class ALU selector and
// the memory sequencer state encoding.
package vector_pkg;

    typedef enum logic [4:0] {
        G3_VADD = 5'b10000,
        G3_VSUB = 5'b10001,
        G3_VMUL = 5'b10010,
        G3_VLDR = 5'b10100,
        G3_VSTR = 5'b10101
    } vec_opcode_e;

    localparam logic [1:0] ALU_VEC_MEM = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_DONE  = 2'b10,
        S_ERR   = 2'b11
    } vms_state_e;

    // A launch is legal only for the memory ALU class with exactly one direction flag.
    function automatic logic vms_start_legal(input logic [1:0] alu_sel,
                                             input logic       rd_flag,
                                             input logic       wr_flag);
        return (alu_sel == ALU_VEC_MEM) && (rd_flag ^ wr_flag);
    endfunction

endpackage

// File: rtl/vms_addr_gen.sv
// Lane counter and per-lane byte address generator for the vector memory
// sequencer; the address wraps modulo 2^ADDR_W.
module vms_addr_gen #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic                       i_advance,
    input  logic [ADDR_W-1:0]          i_base,
    output logic [$clog2(LANES)-1:0]   o_lane,
    output logic [ADDR_W-1:0]          o_addr,
    output logic                       o_last
);
    localparam int LW     = $clog2(LANES);
    localparam int STRIDE = DATA_W / 8;

    logic [LW-1:0]     r_lane;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_offset;

    // Latch base and restart at lane 0 on launch, step one lane per accepted ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            r_base <= '0;
        end else if (i_load) begin
            r_lane <= '0;
            r_base <= i_base;
        end else if (i_advance) begin
            r_lane <= r_lane + LW'(1);
        end
    end

    assign w_offset = ADDR_W'(r_lane) * ADDR_W'(STRIDE);
    assign o_addr   = r_base + w_offset;
    assign o_lane   = r_lane;
    assign o_last   = (r_lane == LW'(LANES - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits a vector load/store into LANES scalar req/ack memory transactions.
// Optional ack-wait timeout is enabled by defining VMS_TIMEOUT_EN.
module vector_mem_sequencer
    import vector_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                ALU_Vectorial,
    input  logic                      Vector_Read,
    input  logic                      MemWrite_vector,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*DATA_W-1:0]   store_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [LANES*DATA_W-1:0]   load_data,
    output logic                      vrf_we,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int LW = $clog2(LANES);

    vms_state_e               r_state;
    vms_state_e               w_next_state;
    logic                     r_is_load;
    logic [LANES*DATA_W-1:0]  r_store_data;
    logic [LANES*DATA_W-1:0]  r_load_data;
    logic                     w_accept;
    logic                     w_advance;
    logic                     w_capture;
    logic                     w_timeout;
    logic                     w_last;
    logic [LW-1:0]            w_lane;
    logic [ADDR_W-1:0]        w_addr;

    assign w_accept  = (r_state == S_IDLE) && start &&
                       vms_start_legal(ALU_Vectorial, Vector_Read, MemWrite_vector);
    assign w_advance = (r_state == S_ISSUE) && mem_ack && !w_last;
    assign w_capture = (r_state == S_ISSUE) && mem_ack && r_is_load;

    vms_addr_gen #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_advance (w_advance),
        .i_base    (base_addr),
        .o_lane    (w_lane),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

`ifdef VMS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Counts consecutive ISSUE cycles without an acknowledge; idle states hold it at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_ISSUE) || mem_ack) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_ISSUE) && !mem_ack &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
`endif

    // State register plus latched operation context and assembled load vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_load    <= 1'b0;
            r_store_data <= '0;
            r_load_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_is_load    <= Vector_Read;
                r_store_data <= store_data;
            end
            if (w_capture) begin
                r_load_data[w_lane*DATA_W +: DATA_W] <= mem_rdata;
            end
        end
    end

    // Next-state logic; a start outside IDLE never reaches this decision
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_accept ? S_ISSUE : S_ERR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_ack && w_last) begin
                    w_next_state = S_DONE;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // All outputs decode from registered state/context, so they stay stable until ack
    assign mem_req   = (r_state == S_ISSUE);
    assign mem_we    = (r_state == S_ISSUE) && !r_is_load;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_store_data[w_lane*DATA_W +: DATA_W];
    assign load_data = r_load_data;
    assign busy      = (r_state == S_ISSUE) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign vrf_we    = (r_state == S_DONE) && r_is_load;
    assign err       = (r_state == S_ERR);

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: directed plan cases plus random
// operations against a transaction-level reference model.
module tb_vector_mem_sequencer;
    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TO_CYC = 8;
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        ALU_Vectorial = 2'b00;
    logic              Vector_Read = 1'b0;
    logic              MemWrite_vector = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [VW-1:0]     store_data = '0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [VW-1:0]     load_data;
    logic              vrf_we, busy, done, err;

    vector_mem_sequencer #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ALU_Vectorial(ALU_Vectorial),
        .Vector_Read(Vector_Read), .MemWrite_vector(MemWrite_vector),
        .base_addr(base_addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(load_data),
        .vrf_we(vrf_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } tx_t;
    typedef struct { bit is_err; bit is_load; logic [VW-1:0] data; int t0; int lat; } ev_t;

    tx_t            txq[$];
    ev_t            evq[$];
    logic [31:0]    rdq[$];
    logic [VW-1:0]  last_load = '0;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    bit             in_reset = 1'b1;
    bit             hold_ack = 1'b0;
    bit             spurious_en = 1'b0;
    int             ack_delay = 0;
    int             cur_delay = 0;
    int             wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory responder: waits cur_delay cycles per transaction, may ack spuriously when idle
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req && !hold_ack && !rst) begin
                if (wcnt >= cur_delay) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = (rdq.size() > 0) ? rdq.pop_front() : $urandom;
                    wcnt = 0;
                    cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                end else begin
                    wcnt++;
                end
            end else if (!mem_req && spurious_en) begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: compares every memory transaction and completion pulse with the scoreboard
    initial begin
        tx_t tx; ev_t ev;
        logic pr_req = 1'b0, pr_ack = 1'b0, pr_we = 1'b0;
        logic [31:0] pr_addr = '0, pr_wd = '0;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (mem_req) begin
                    chk("req_expected", VW'(txq.size() > 0), VW'(1));
                    if (pr_req && !pr_ack) begin
                        chk("hold_addr", mem_addr, pr_addr);
                        chk("hold_we", mem_we, pr_we);
                        chk("hold_wdata", mem_wdata, pr_wd);
                    end
                    if (mem_ack && txq.size() > 0) begin
                        tx = txq.pop_front();
                        chk("txn_addr", mem_addr, tx.addr);
                        chk("txn_we", mem_we, tx.we);
                        if (tx.we) chk("txn_wdata", mem_wdata, tx.wdata);
                    end
                end
                if (done || err || vrf_we) begin
                    if (evq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse actual done=%0b err=%0b vrf_we=%0b required none",
                                 done, err, vrf_we);
                    end else begin
                        ev = evq.pop_front();
                        chk("done", done, !ev.is_err);
                        chk("err", err, ev.is_err);
                        chk("vrf_we", vrf_we, !ev.is_err && ev.is_load);
                        if (!ev.is_err && ev.is_load) last_load = ev.data;
                        chk("load_data", load_data, last_load);
                        chk("busy_at_end", busy, !ev.is_err);
                        if (ev.lat >= 0) chk("latency", VW'(cyc - ev.t0), VW'(ev.lat));
                    end
                end
            end
            pr_req = mem_req && !in_reset;
            pr_ack = mem_ack; pr_addr = mem_addr; pr_we = mem_we; pr_wd = mem_wdata;
        end
    end

    task automatic launch(input logic [1:0] alu, input logic rd, input logic wr,
                          input logic [31:0] base, input logic [VW-1:0] sdata,
                          input logic [VW-1:0] rvec, input int dly, input bit chk_lat,
                          input bit exp_timeout);
        ev_t ev; tx_t tx;
        bit legal;
        legal = (alu == 2'b11) && (rd != wr);
        ev.is_err  = !legal || exp_timeout;
        ev.is_load = legal && rd && !exp_timeout;
        ev.data    = rvec;
        ev.lat     = !legal ? 1 : exp_timeout ? TO_CYC + 1 :
                     (chk_lat && dly >= 0) ? LANES * (dly + 1) + 1 : -1;
        if (legal) begin
            for (int i = 0; i < LANES; i++) begin
                tx.addr  = base + 32'(i * (DATA_W / 8));
                tx.we    = wr;
                tx.wdata = sdata[i*DATA_W +: DATA_W];
                txq.push_back(tx);
                if (rd && !exp_timeout) rdq.push_back(rvec[i*DATA_W +: DATA_W]);
            end
        end
        @(posedge clk); #1;
        ev.t0 = cyc;
        evq.push_back(ev);
        ack_delay = dly;
        cur_delay = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        wcnt = 0;
        ALU_Vectorial = alu; Vector_Read = rd; MemWrite_vector = wr;
        base_addr = base; store_data = sdata; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Vector_Read = 1'b0; MemWrite_vector = 1'b0; ALU_Vectorial = 2'b00;
    endtask

    task automatic pulse_ignored_start(input logic rd, input logic wr);
        @(posedge clk); #1;
        ALU_Vectorial = 2'b11; Vector_Read = rd; MemWrite_vector = wr;
        base_addr = 32'h0000_5550; store_data = {VW/32{32'hDEAD_BEEF}}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Vector_Read = 1'b0; MemWrite_vector = 1'b0; ALU_Vectorial = 2'b00;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((evq.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_wait actual=timeout required=idle", nm);
        end
    endtask

    task automatic zero_check();
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_load_data", load_data, 0); chk("rst_vrf_we", vrf_we, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        in_reset = 1'b1; hold_ack = 1'b1; rst = 1'b1;
        txq.delete(); rdq.delete(); evq.delete(); last_load = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        zero_check();
        @(posedge clk); #1;
        rst = 1'b0; hold_ack = 1'b0; in_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=stuck required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] rv, sd;
        do_reset(3);

        // Plan: aligned load, ack every cycle, latency LANES+1
        launch(2'b11, 1'b1, 1'b0, 32'h0000_0100, '0,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b1, 1'b0);
        wait_idle("load_basic");
        // Plan: store with 3-cycle ack delay, plus ignored starts mid-operation
        launch(2'b11, 1'b0, 1'b1, 32'h0000_0200, {32'h44, 32'h33, 32'h22, 32'h11},
               '0, 3, 1'b1, 1'b0);
        pulse_ignored_start(1'b1, 1'b0);
        pulse_ignored_start(1'b1, 1'b1);
        wait_idle("store_delay");
        // Plan: illegal launches
        launch(2'b11, 1'b1, 1'b1, 32'h0000_0300, '0, '0, 0, 1'b1, 1'b0);
        wait_idle("err_both");
        launch(2'b00, 1'b1, 1'b0, 32'h0000_0300, '0, '0, 0, 1'b1, 1'b0);
        wait_idle("err_alu");
        launch(2'b11, 1'b0, 1'b0, 32'h0000_0300, '0, '0, 0, 1'b1, 1'b0);
        wait_idle("err_none");
        // Plan: address wrap at top of space
        launch(2'b11, 1'b1, 1'b0, 32'hFFFF_FFF8, '0,
               {32'h0D, 32'h0C, 32'h0B, 32'h0A}, 1, 1'b1, 1'b0);
        wait_idle("load_wrap");

        // Plan: reset during lane 2 of a load, with a second start mid-op
        launch(2'b11, 1'b1, 1'b0, 32'h0000_0400, '0,
               {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1'b0);
        for (int n = 0; n < 50 && txq.size() > LANES - 2; n++) begin
            @(posedge clk); #1;
        end
        chk("reached_lane2", VW'(txq.size()), VW'(LANES - 2));
        pulse_ignored_start(1'b0, 1'b1);
        do_reset(2);
        launch(2'b11, 1'b1, 1'b0, 32'h0000_0500, '0,
               {32'h5, 32'h6, 32'h7, 32'h8}, 0, 1'b1, 1'b0);
        wait_idle("after_reset");

        // Plan: ack withheld
        hold_ack = 1'b1;
`ifdef VMS_TIMEOUT_EN
        launch(2'b11, 1'b1, 1'b0, 32'h0000_0600, '0, '0, 0, 1'b0, 1'b1);
        wait_idle("timeout");
        txq.delete();
        hold_ack = 1'b0;
`else
        launch(2'b11, 1'b1, 1'b0, 32'h0000_0600, '0, '0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("stall_busy", busy, 1);
            chk("stall_req", mem_req, 1);
        end
        do_reset(1);
`endif

        // Random operations against the scoreboard model
        spurious_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  alu;
            logic [31:0] base;
            alu  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                               : $urandom;
            sd = {$urandom, $urandom, $urandom, $urandom};
            rv = {$urandom, $urandom, $urandom, $urandom};
            launch(alu, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base, sd, rv,
                   ($urandom_range(0, 1) == 0) ? -1 : 0, 1'b1, 1'b0);
            wait_idle("random");
        end
        spurious_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("txq_drained", VW'(txq.size()), VW'(0));
        chk("evq_drained", VW'(evq.size()), VW'(0));
        chk("rdq_drained", VW'(rdq.size()), VW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Consumes the decoded vector memory-control signals (Vector_Read / MemWrite_vector, ALU_Vectorial = 2'b11) for G3_VLDR / G3_VSTR.
- Splits one vector load/store into LANES sequential scalar data-memory transactions using a req/ack handshake.
- Assembles loaded lanes and emits a single vector-register-file write pulse.
- Sits between the vector decode stage and the data memory; stalls the pipeline via busy.

Parameters:
- LANES, 4, number of vector lanes (power of two, 2..16).
- DATA_W, 32, bits per lane.
- ADDR_W, 32, byte address width.
- TIMEOUT_CYC, 64, ack-wait cycle limit (used only with VMS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to launch an operation.
- ALU_Vectorial  in  2  must be 2'b11 for start to be accepted.
- Vector_Read  in  1  load request (VLDR).
- MemWrite_vector  in  1  store request (VSTR).
- base_addr  in  ADDR_W  byte address of lane 0.
- store_data  in  LANES*DATA_W  store vector; lane i at bits [i*DATA_W +: DATA_W].
- mem_req  out  1  scalar transaction valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  scalar address.
- mem_wdata  out  DATA_W  scalar write data.
- mem_ack  in  1  memory accepted/completed the transaction this cycle.
- mem_rdata  in  DATA_W  read data; valid with mem_ack on reads.
- load_data  out  LANES*DATA_W  assembled load vector.
- vrf_we  out  1  one-cycle vector register write strobe (loads only).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal/aborted pulse.

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous and active-high.
- Reset: all outputs 0, load_data 0, state IDLE, lane counter 0.
- Reset asserted mid-operation abandons the operation with no done, err or vrf_we.
- States: IDLE, ISSUE, DONE, ERR.
- IDLE:
  - start with ALU_Vectorial = 2'b11 and exactly one of Vector_Read / MemWrite_vector -> latch op, base_addr and store_data; lane = 0; go to ISSUE.
  - start with both or neither flag set, or ALU_Vectorial != 2'b11 -> ERR.
  - start while not in IDLE is ignored.
- ISSUE:
  - mem_req = 1; mem_addr = base + lane*(DATA_W/8), truncated modulo 2^ADDR_W (wraps at top of address space).
  - mem_we = latched store flag; mem_wdata = latched lane word.
  - mem_req, mem_addr, mem_wdata and mem_we are held stable until mem_ack.
  - On mem_ack for a load: capture mem_rdata into load_data lane[lane].
  - mem_ack with lane == LANES-1 -> DONE; otherwise lane+1, and mem_req stays high (back-to-back allowed).
  - mem_ack while mem_req = 0 is ignored.
- DONE: done = 1 for one cycle; vrf_we = 1 in the same cycle for loads only; go to IDLE.
  - load_data holds its value until the next load completes.
- ERR: err = 1 for one cycle; go to IDLE; no memory traffic.
- busy = 1 in ISSUE and DONE.
- Minimum latency: start to done = LANES+1 cycles with ack every cycle.
- Untouched lanes of load_data are retained; a load always writes every lane.

Optional Feature:
- Macro: VMS_TIMEOUT_EN.
- Defined:
  - Counter clears on each mem_ack and on ISSUE entry.
  - If TIMEOUT_CYC consecutive ISSUE cycles pass without mem_ack: drop mem_req, go to ERR; no vrf_we.
- Undefined: no counter; the block waits indefinitely for mem_ack.

Decomposition:
- Shared package vector_pkg:
  - Opcode enum (G3_VADD 10000, G3_VSUB 10001, G3_VMUL 10010, G3_VLDR 10100, G3_VSTR 10101).
  - ALU_VEC_MEM = 2'b11 constant.
  - Sequencer state enum.
- Sub-module vms_addr_gen: lane counter plus address adder, with last-lane flag.

Test Plan:
- VLDR, LANES=4, base 0x100, ack every cycle, rdata 0xA0..0xA3 -> addrs 0x100/104/108/10C; load_data = {A3,A2,A1,A0}; vrf_we and done at cycle 5.
- VSTR, store_data = {44,33,22,11}, ack delayed 3 cycles per lane -> mem_we = 1; wdata 11,22,33,44 held stable during waits; done with vrf_we = 0.
- Vector_Read = MemWrite_vector = 1, or ALU_Vectorial = 2'b00, on start -> err pulse next cycle; mem_req never asserted.
- base 0xFFFFFFF8 load -> addrs FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- rst pulsed during lane 2 of a load; second start mid-op -> outputs cleared, no done; mid-op start ignored.
- With VMS_TIMEOUT_EN, TIMEOUT_CYC=8, ack withheld -> mem_req drops and err pulses after 8 cycles; without the macro, busy stays high.
